pipe_stage_reg: RTL

Generic, parametrised pipeline stage register that replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the miyajiro CPU. It carries an opaque data payload and a control field across a valid/ready handshake, so the hazard unit does not need a global write_enable. Flush inserts a bubble, and an optional skid slot keeps full throughput with a registered `in_ready`. Each stage of the core instantiates it once between two pipeline stages.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_slot.sv | 55 +++++
 rtl/pipe_stage_reg.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage register and its slots.
package pipe_pkg;

  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CTRL_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: valid + payload + control, load-enabled, sync reset, ctrl cleared when invalid.
// Loading an invalid entry keeps the old payload so only the control field turns into a bubble.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_en,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              vld,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (ld_en) begin
      vld_d = vld_in;
      if (vld_in) begin
        data_d = data_in;
        ctrl_d = ctrl_in;
      end else begin
        ctrl_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ctrl_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign vld  = vld_q;
  assign data = data_q;
  assign ctrl = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush-to-bubble; 1-cycle latency, full throughput.
// SKID=1 adds a skid slot so in_ready is registered; SKID=0 uses combinational in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              push;
  logic              pop;
  logic              main_ld;
  logic              main_vld_in;
  logic [DATA_W-1:0] main_data_in;
  logic [CTRL_W-1:0] main_ctrl_in;

  // A flush cycle never accepts input, even when in_ready is high.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready;

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .ld_en   (main_ld),
    .vld_in  (main_vld_in),
    .data_in (main_data_in),
    .ctrl_in (main_ctrl_in),
    .vld     (out_valid),
    .data    (out_data),
    .ctrl    (out_ctrl)
  );

  if (SKID != 0) begin : g_skid
    pipe_state_e       state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              skid_ld;
    logic              skid_vld_in;
    logic              skid_vld;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .ld_en   (skid_ld),
      .vld_in  (skid_vld_in),
      .data_in (in_data),
      .ctrl_in (in_ctrl),
      .vld     (skid_vld),
      .data    (skid_data),
      .ctrl    (skid_ctrl)
    );

    always_comb begin
      state_d      = state_q;
      main_ld      = 1'b0;
      main_vld_in  = 1'b0;
      main_data_in = in_data;
      main_ctrl_in = in_ctrl;
      skid_ld      = 1'b0;
      skid_vld_in  = 1'b0;
      if (flush) begin
        state_d = EMPTY;
        main_ld = 1'b1;
        skid_ld = 1'b1;
      end else begin
        case (state_q)
          EMPTY: begin
            if (push) begin
              state_d     = ONE;
              main_ld     = 1'b1;
              main_vld_in = 1'b1;
            end
          end
          ONE: begin
            if (push && !pop) begin
              state_d     = TWO;
              skid_ld     = 1'b1;
              skid_vld_in = 1'b1;
            end else if (push && pop) begin
              main_ld     = 1'b1;
              main_vld_in = 1'b1;
            end else if (pop) begin
              state_d = EMPTY;
              main_ld = 1'b1;
            end
          end
          TWO: begin
            // Older skid entry moves up; the input is blocked by in_ready in this state.
            if (pop) begin
              state_d      = ONE;
              main_ld      = 1'b1;
              main_vld_in  = skid_vld;
              main_data_in = skid_data;
              main_ctrl_in = skid_ctrl;
              skid_ld      = 1'b1;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
      in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_q    <= EMPTY;
        in_ready_q <= 1'b1;
      end else begin
        state_q    <= state_d;
        in_ready_q <= in_ready_d;
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_noskid
    // The main slot's valid bit is the whole EMPTY/ONE state here.
    assign in_ready = !out_valid || out_ready;

    always_comb begin
      main_ld      = 1'b0;
      main_vld_in  = 1'b0;
      main_data_in = in_data;
      main_ctrl_in = in_ctrl;
      if (flush) begin
        main_ld = 1'b1;
      end else if (push) begin
        main_ld     = 1'b1;
        main_vld_in = 1'b1;
      end else if (pop) begin
        main_ld = 1'b1;
      end
    end
  end

endmodule
